fetch_ctrl: RTL and testbench

Sequencer for the fetch stage. It drives the PC register's next-PC, stall and redirect controls, and tracks the one in-flight instruction-memory read (synchronous, 1-cycle latency). It queues fetched instructions in a small skid buffer and presents them to decode on a valid/ready handshake. Branch-predictor redirects, backend mispredict redirects and decode backpressure are all arbitrated here.

---
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: next-PC selection, stall/redirect control, tracking of the single
// in-flight instruction-memory read, and a small skid buffer feeding decode.
module fetch_ctrl #(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] pc_update,
    output logic            stall,
    output logic            mispredicted,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            bp_taken,
    input  logic [XLEN-1:0] bp_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_pred_taken
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             iss_valid_q, iss_valid_d;
    logic [XLEN-1:0]  iss_pc_q, iss_pc_d;
    logic             iss_pred_q, iss_pred_d;

    logic [XLEN-1:0]  buf_pc_q    [BUF_DEPTH];
    logic [XLEN-1:0]  buf_pc_d    [BUF_DEPTH];
    logic [XLEN-1:0]  buf_instr_q [BUF_DEPTH];
    logic [XLEN-1:0]  buf_instr_d [BUF_DEPTH];
    logic             buf_pred_q  [BUF_DEPTH];
    logic             buf_pred_d  [BUF_DEPTH];

    logic             deq;
    logic             enq;
    logic [CNT_W:0]   occ;

    // Occupancy once this cycle's dequeue and the in-flight read have settled.
    assign occ = {1'b0, count_q} - (CNT_W + 1)'(deq) + (CNT_W + 1)'(iss_valid_q);

    always_comb begin
        if (reset) begin
            pc_update = RESET_PC;
        end else if (redirect_valid) begin
            pc_update = redirect_pc;
        end else if (bp_taken) begin
            pc_update = bp_target;
        end else begin
            pc_update = pc_cur + XLEN'(4);
        end
    end

    assign mispredicted   = redirect_valid & ~reset;
    assign out_valid      = ~reset & ~redirect_valid & (count_q != '0);
    assign deq            = out_valid & out_ready;
    assign enq            = iss_valid_q & ~redirect_valid;
    assign stall          = ~reset & ~redirect_valid & (occ >= (CNT_W + 1)'(BUF_DEPTH));
    assign out_pc         = buf_pc_q[head_q];
    assign out_instr      = buf_instr_q[head_q];
    assign out_pred_taken = buf_pred_q[head_q];

    always_comb begin
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pred_d  = buf_pred_q;
        iss_valid_d = ~stall & ~redirect_valid;
        iss_pc_d    = iss_pc_q;
        iss_pred_d  = iss_pred_q;

        if (iss_valid_d) begin
            iss_pc_d   = pc_cur;
            iss_pred_d = bp_taken;
        end

        if (redirect_valid) begin
            // Flush: the in-flight read and every buffered entry are wrong-path.
            count_d = '0;
            head_d  = tail_q;
        end else begin
            if (enq) begin
                buf_pc_d[tail_q]    = iss_pc_q;
                buf_instr_d[tail_q] = instr_in;
                buf_pred_d[tail_q]  = iss_pred_q;
                tail_d              = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            iss_valid_q <= iss_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        iss_pc_q    <= iss_pc_d;
        iss_pred_q  <= iss_pred_d;
        buf_pc_q    <= buf_pc_d;
        buf_instr_q <= buf_instr_d;
        buf_pred_q  <= buf_pred_d;
    end

    // The stall rule must keep a slot free for every read that is issued.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            assert (count_q != CNT_W'(BUF_DEPTH));
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register and 1-cycle instruction memory.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] instr_in;
    logic [31:0] pc_update;
    logic        stall;
    logic        mispredicted;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_taken;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    fetch_ctrl #(
        .XLEN      (32),
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .instr_in       (instr_in),
        .pc_update      (pc_update),
        .stall          (stall),
        .mispredicted   (mispredicted),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bp_taken       (bp_taken),
        .bp_target      (bp_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_pred_taken (out_pred_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // PC register and synchronous instruction memory.
    always @(posedge clk) begin
        if (reset || mispredicted || !stall) pc_cur <= pc_update;
        instr_in <= imem(pc_cur);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic pred);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, imem(pc));
        chk({tag, "_pred"}, {31'b0, out_pred_taken}, {31'b0, pred});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    // Cycle 0 is the first cycle with reset low.
    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234;
        bp_taken       = 1'b1;
        bp_target      = 32'h88;
        out_ready      = 1'b1;
        @(posedge clk);
        #1;
        settle();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mispred", {31'b0, mispredicted}, 32'd0);
        chk("rst_pc_update", pc_update, 32'h0);
        redirect_valid = 1'b0;
        bp_taken       = 1'b0;
        do_reset();

        // Sequential stream, one instruction per cycle.
        settle();
        chk("seq_c0_valid", {31'b0, out_valid}, 32'd0);
        run_to(1);
        settle();
        chk("seq_c1_valid", {31'b0, out_valid}, 32'd0);
        for (int c = 2; c <= 4; c++) begin
            run_to(c);
            settle();
            check_out("seq", 32'(4 * (c - 2)), 1'b0);
            chk("seq_stall", {31'b0, stall}, 32'd0);
        end

        // Backpressure from cycle 5: buffer fills, PC holds, then drains in order.
        run_to(5);
        out_ready = 1'b0;
        settle();
        check_out("bp5", 32'hC, 1'b0);
        chk("bp5_stall", {31'b0, stall}, 32'd1);
        run_to(6);
        settle();
        check_out("bp6", 32'hC, 1'b0);
        chk("bp6_stall", {31'b0, stall}, 32'd1);
        run_to(7);
        settle();
        check_out("bp7", 32'hC, 1'b0);
        chk("bp7_stall", {31'b0, stall}, 32'd1);
        chk("bp7_pc_hold", pc_cur, 32'h14);
        run_to(8);
        out_ready = 1'b1;
        settle();
        check_out("drain8", 32'hC, 1'b0);
        chk("drain8_stall", {31'b0, stall}, 32'd0);
        for (int c = 9; c <= 11; c++) begin
            run_to(c);
            settle();
            check_out("drain", 32'(16 + 4 * (c - 9)), 1'b0);
        end

        // Predicted-taken branch at pc 0x8.
        do_reset();
        run_to(2);
        bp_taken  = 1'b1;
        bp_target = 32'h100;
        settle();
        chk("br_pc_update", pc_update, 32'h100);
        check_out("br_c2", 32'h0, 1'b0);
        run_to(3);
        bp_taken = 1'b0;
        settle();
        check_out("br_c3", 32'h4, 1'b0);
        run_to(4);
        settle();
        check_out("br_c4", 32'h8, 1'b1);
        run_to(5);
        settle();
        check_out("br_c5", 32'h100, 1'b0);
        run_to(6);
        settle();
        check_out("br_c6", 32'h104, 1'b0);

        // Redirect with a full buffer, stall pending and a competing prediction.
        out_ready = 1'b0;
        do_reset();
        run_to(2);
        settle();
        chk("rd_c2_stall", {31'b0, stall}, 32'd1);
        run_to(3);
        settle();
        chk("rd_c3_stall", {31'b0, stall}, 32'd1);
        chk("rd_c3_pc", pc_cur, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        bp_taken       = 1'b1;
        bp_target      = 32'h200;
        out_ready      = 1'b1;
        settle();
        chk("rd_mispred", {31'b0, mispredicted}, 32'd1);
        chk("rd_stall", {31'b0, stall}, 32'd0);
        chk("rd_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rd_pc_update", pc_update, 32'h40);
        run_to(4);
        redirect_valid = 1'b0;
        bp_taken       = 1'b0;
        settle();
        chk("rd_c4_valid", {31'b0, out_valid}, 32'd0);
        chk("rd_c4_mispred", {31'b0, mispredicted}, 32'd0);
        run_to(5);
        settle();
        chk("rd_c5_valid", {31'b0, out_valid}, 32'd0);
        run_to(6);
        settle();
        check_out("rd_c6", 32'h40, 1'b0);
        run_to(7);
        settle();
        check_out("rd_c7", 32'h44, 1'b0);

        // Back-to-back redirects: the second one wins.
        run_to(8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        settle();
        chk("b2b_c8_valid", {31'b0, out_valid}, 32'd0);
        run_to(9);
        redirect_pc = 32'hC0;
        settle();
        chk("b2b_c9_pc_update", pc_update, 32'hC0);
        chk("b2b_c9_valid", {31'b0, out_valid}, 32'd0);
        run_to(10);
        redirect_valid = 1'b0;
        settle();
        chk("b2b_c10_valid", {31'b0, out_valid}, 32'd0);
        run_to(11);
        settle();
        chk("b2b_c11_valid", {31'b0, out_valid}, 32'd0);
        run_to(12);
        settle();
        check_out("b2b_c12", 32'hC0, 1'b0);
        run_to(13);
        settle();
        check_out("b2b_c13", 32'hC4, 1'b0);

        // Sequential wrap at the top of the address space.
        run_to(14);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        run_to(15);
        redirect_valid = 1'b0;
        settle();
        chk("wrap_c15_pc_update", pc_update, 32'hFFFF_FFFC);
        run_to(16);
        settle();
        chk("wrap_c16_pc", pc_cur, 32'hFFFF_FFFC);
        chk("wrap_c16_pc_update", pc_update, 32'h0);
        run_to(17);
        settle();
        check_out("wrap_c17", 32'hFFFF_FFF8, 1'b0);
        run_to(18);
        settle();
        check_out("wrap_c18", 32'hFFFF_FFFC, 1'b0);
        run_to(19);
        settle();
        check_out("wrap_c19", 32'h0, 1'b0);
        out_ready = 1'b0;

        // Reset mid-stream with two entries buffered.
        run_to(20);
        settle();
        check_out("mid_c20", 32'h0, 1'b0);
        chk("mid_c20_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1;
        settle();
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_pc_update", pc_update, 32'h0);
        next_cycle();
        reset     = 1'b0;
        out_ready = 1'b1;
        cyc       = 0;
        settle();
        chk("post_rst_c0_valid", {31'b0, out_valid}, 32'd0);
        run_to(1);
        settle();
        chk("post_rst_c1_valid", {31'b0, out_valid}, 32'd0);
        run_to(2);
        settle();
        check_out("post_rst_c2", 32'h0, 1'b0);
        run_to(3);
        settle();
        check_out("post_rst_c3", 32'h4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
